serial_adder_ctrl: RTL and testbench

//  Bit-serial adder sequencer that sits directly upstream of the single-bit full-adder cell.
//  - Latches two WIDTH-bit operands and a carry-in.
//  - Presents one bit pair plus the running carry to the cell per clock, LSB first.
//  - Collects the cell's sum/carry outputs and returns a WIDTH-bit sum and carry-out with a

---
 rtl/serial_adder_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder sequencer. It sits directly upstream of an external
// single-bit full-adder cell and drives one bit pair plus the running carry
// per clock, LSB first. It collects the cell's sum and carry and returns a
// WIDTH-bit sum and a carry-out.
//
// Handshake: start is sampled only in IDLE. An accepted start moves the block
// to RUN, where busy=1. After WIDTH bit cycles the block enters DONE for
// exactly one cycle, with done=1 and busy=1, and then returns to IDLE.
// A start seen while busy is dropped and is not queued. sum/cout/ovf change
// only on the completion edge and hold their value otherwise.
//
// Optional feature: define OVERFLOW_DETECT_EN to compute the signed
// two's-complement overflow flag on ovf. When the macro is not defined,
// ovf is tied to 0 and no flop is built for it.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous reset, active-high
//   start     in   1      operation request (sampled in IDLE)
//   a, b      in   WIDTH  operands, captured on accept
//   cin       in   1      carry-in, captured on accept
//   fa_a      out  1      operand A bit to full-adder cell
//   fa_b      out  1      operand B bit to full-adder cell
//   fa_c      out  1      running carry to full-adder cell
//   fa_sum    in   1      full-adder sum (combinational return)
//   fa_carry  in   1      full-adder carry (combinational return)
//   busy      out  1      high in RUN and DONE
//   done      out  1      one-cycle completion pulse
//   sum       out  WIDTH  result, held between completions
//   cout      out  1      final carry, held between completions
//   ovf       out  1      signed overflow (0 unless OVERFLOW_DETECT_EN)
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic             c_q;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             last_bit;

    assign last_bit = (state == RUN) && (cnt == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and full-adder cell drive. The cell inputs come only from
    // registers, so there is no combinational path from a/b/cin.
    always_comb begin
        state_n = state;
        fa_a    = 1'b0;
        fa_b    = 1'b0;
        fa_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                fa_a = a_sr[0];
                fa_b = b_sr[0];
                fa_c = c_q;
                if (cnt == LAST) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath: operand shifters, partial sum, running carry, bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            psum   <= '0;
            c_q    <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        c_q  <= cin;
                        cnt  <= '0;
                        psum <= '0;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    psum <= {fa_sum, psum[WIDTH-1:1]};
                    c_q  <= fa_carry;
                    // Park the counter at 0 on the last bit so it never holds
                    // a value outside 0..WIDTH-1 for non-power-of-two widths.
                    cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_q  <= {fa_sum, psum[WIDTH-1:1]};
                        cout_q <= fa_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // busy/done are registered from the next state so that they line up with
    // the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_n != IDLE);
            done_q <= (state_n == DONE);
        end
    end

`ifdef OVERFLOW_DETECT_EN
    logic ovf_q;

    // While the MSB is in the cell, c_q is the carry into the MSB and
    // fa_carry is the carry out of it. They differ exactly on signed overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= c_q ^ fa_carry;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Bench for serial_adder_ctrl with WIDTH=8. The fa_* ports are closed by an
// ideal full-adder cell. Expected results come from integer arithmetic on the
// operands. These results are queued in exp_q when an operation is requested
// and are popped when done is observed. Outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             fa_a;
    logic             fa_b;
    logic             fa_c;
    logic             fa_sum;
    logic             fa_carry;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_tests = 0;
    int n_fail  = 0;

    // Result layout: {ovf, cout, sum}
    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH+1:0] last_res;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Ideal single-bit full-adder cell
    assign fa_sum   = fa_a ^ fa_b ^ fa_c;
    assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .fa_a     (fa_a),
        .fa_b     (fa_b),
        .fa_c     (fa_c),
        .fa_sum   (fa_sum),
        .fa_carry (fa_carry),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    // ---------------- reference model ----------------
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic c);
        int   u;
        int   sx;
        int   sy;
        int   s;
        logic o;
        u  = int'(x) + int'(y) + int'(c);
        sx = x[WIDTH-1] ? int'(x) - (1 << WIDTH) : int'(x);
        sy = y[WIDTH-1] ? int'(y) - (1 << WIDTH) : int'(y);
        s  = sx + sy + int'(c);
`ifdef OVERFLOW_DETECT_EN
        o = (s > (1 << (WIDTH - 1)) - 1) || (s < -(1 << (WIDTH - 1)));
`else
        o = 1'b0;
`endif
        return {o, u[WIDTH], u[WIDTH-1:0]};
    endfunction

    // Carry into bit position pos of x + y + c
    function automatic logic carry_into(input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y,
                                        input logic c, input int pos);
        int m;
        int t;
        m = (1 << pos) - 1;
        t = ((int'(x) & m) + (int'(y) & m) + int'(c)) >> pos;
        return t[0];
    endfunction

    // ---------------- driver tasks ----------------
    // Call this task at a falling edge while the DUT is idle. It returns at
    // the falling edge after the DUT is back in IDLE. When noisy is set,
    // start is pulsed with random operands while the DUT is busy.
    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input logic op_cin, input bit noisy);
        logic [WIDTH+1:0] exp;
        logic             ce;
        a     = op_a;
        b     = op_b;
        cin   = op_cin;
        start = 1'b1;
        exp_q.push_back(model(op_a, op_b, op_cin));
        @(negedge clk);
        start = noisy;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom_range(0, 1));
        for (int pos = 0; pos <= WIDTH; pos++) begin
            n_tests++;
            if (done !== (pos == WIDTH)) begin
                n_fail++;
                $display("FAIL done_timing pos=%0d got done=%b want %b", pos, done, (pos == WIDTH));
            end
            n_tests++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_active pos=%0d got %b want 1", pos, busy);
            end
            if (pos < WIDTH) begin
                ce = carry_into(op_a, op_b, op_cin, pos);
                n_tests++;
                if ({fa_a, fa_b, fa_c} !== {op_a[pos], op_b[pos], ce}) begin
                    n_fail++;
                    $display("FAIL fa_drive pos=%0d got %b%b%b want %b%b%b", pos,
                             fa_a, fa_b, fa_c, op_a[pos], op_b[pos], ce);
                end
                @(negedge clk);
                if (noisy) begin
                    start = 1'($urandom_range(0, 1));
                    a     = WIDTH'($urandom);
                    b     = WIDTH'($urandom);
                end
            end
        end
        exp      = exp_q.pop_front();
        last_res = exp;
        n_tests++;
        if ({ovf, cout, sum} !== exp) begin
            n_fail++;
            $display("FAIL result a=%h b=%h cin=%b got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                     op_a, op_b, op_cin, ovf, cout, sum, exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0]);
        end
        if (noisy) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_return got busy=%b done=%b want 0 0", busy, done);
        end
        n_tests++;
        if ({ovf, cout, sum} !== exp) begin
            n_fail++;
            $display("FAIL result_hold got %h want %h", {ovf, cout, sum}, exp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done);
        end
        n_tests++;
        if ({ovf, cout, sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_result got %h want 0", {ovf, cout, sum});
        end
        n_tests++;
        if ({fa_a, fa_b, fa_c} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_fa got %b%b%b want 000", fa_a, fa_b, fa_c);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(8'h5A, 8'h33, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
        run_op(8'h7F, 8'h00, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        run_op(8'h12, 8'h34, 1'b0, 1'b1);
        run_op(8'hC3, 8'h9E, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 6; i++) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_tests++;
            if ({ovf, cout, sum, busy, done} !== {last_res, 2'b00}) begin
                n_fail++;
                $display("FAIL idle_hold cyc=%0d got %h busy=%b done=%b want %h", i,
                         {ovf, cout, sum}, busy, done, last_res);
            end
        end
    endtask

    task automatic test_abort();
        int seen_done;
        a     = 8'h0F;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_flags got busy=%b done=%b want 0 0", busy, done);
        end
        n_tests++;
        if ({ovf, cout, sum} !== '0) begin
            n_fail++;
            $display("FAIL abort_result got %h want 0", {ovf, cout, sum});
        end
        n_tests++;
        if ({fa_a, fa_b, fa_c} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_fa got %b%b%b want 000", fa_a, fa_b, fa_c);
        end
        rst       = 1'b0;
        seen_done = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_tests++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL abort_no_done got %0d active cycles want 0", seen_done);
        end
        run_op(8'h0F, 8'h01, 1'b0, 1'b0);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_random();
        test_hold();
        test_abort();
        test_hold();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
